rocc_cmd_responder: RTL and testbench
=====================================

ROCC_CMD_RESPONDER -- requirements
Module: rocc_cmd_responder

Interface
REQ-001 SHALL have parameter DIM_W, default 10: width of each matrix dimension field (M, N, K).
REQ-002 SHALL have parameter TMO_W, default 16: width of the watchdog counter; used only when ROCC_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: one-cycle command pulse from the core-side RoCC controller.
REQ-006 SHALL have port cmd_instr, input, 32: the custom instruction word.
REQ-007 SHALL have ports cmd_rs1 and cmd_rs2, input, 32 each: forwarded source operands.
REQ-008 SHALL have port cmd_done, output, 1: one-cycle completion pulse; releases the core stall.
REQ-009 SHALL have ports cfg_a_addr, cfg_b_addr and cfg_c_addr, output, 32 each: operand and result base addresses.
REQ-010 SHALL have ports cfg_m, cfg_n and cfg_k, output, DIM_W each: matrix dimensions.
REQ-011 SHALL have port engine_start, output, 1: one-cycle start pulse to the systolic engine.
REQ-012 SHALL have port engine_done, input, 1: one-cycle engine completion pulse.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-014 SHALL have port err, output, 3: sticky error flags {timeout, overrun, illegal}.

Function
REQ-015 SHALL implement FSM states IDLE, RESP, START, WAIT and DONE.
REQ-016 SHALL accept a command only when the state is IDLE and cmd_valid=1.
- Accepted command is registered on that clock edge (cycle N).
REQ-017 SHALL treat a command as legal only if cmd_instr[6:0]=7'b0001011 (custom-0).
REQ-018 SHALL decode cmd_instr[31:25] as follows:
- 0x00 SETAB: cfg_a_addr<=rs1, cfg_b_addr<=rs2.
- 0x01 SETCD: cfg_c_addr<=rs1, cfg_m<=rs2[DIM_W-1:0], cfg_n<=rs2[2*DIM_W-1:DIM_W], cfg_k<=rs2[3*DIM_W-1:2*DIM_W].
- 0x02 COMPUTE.
- 0x03 CLRERR: err<=0.
REQ-019 SHALL, for SETAB, SETCD and CLRERR, update the targeted registers at the end of cycle N, go to RESP, and pulse cmd_done in cycle N+1.
REQ-020 SHALL, for an illegal opcode or funct7, leave the cfg registers unchanged, set err[0], and pulse cmd_done in cycle N+1.
REQ-021 SHALL, for COMPUTE with cfg_m, cfg_n or cfg_k equal to 0, treat the command as illegal (per REQ-020) and SHALL NOT pulse engine_start.
REQ-022 SHALL, for a valid COMPUTE, pulse engine_start in cycle N+1 (START state), then enter WAIT.
REQ-023 SHALL recognise engine_done only while in WAIT; an engine_done in START or any other state SHALL be ignored.
REQ-024 SHALL, on engine_done in WAIT during cycle W, pulse cmd_done in cycle W+1 (DONE state), then return to IDLE.
REQ-025 SHALL, on cmd_valid=1 in any non-IDLE state, ignore the command and set err[1].
REQ-026 SHALL hold the cfg registers stable while busy=1.
REQ-027 SHALL keep cmd_done and engine_start low in all states other than those named in REQ-019, REQ-020, REQ-022 and REQ-024.
REQ-028 SHALL, for a CLRERR command that is itself accepted, let the clear take precedence over any error flag that would be set in the same cycle.

Reset
REQ-029 SHALL, while rst=1, immediately force the following, regardless of any in-flight command:
- state to IDLE;
- every cfg output, err and the watchdog counter to 0;
- cmd_done, engine_start and busy to 0.
REQ-030 SHALL accept a command on the first rising edge on which rst=0 and cmd_valid=1.

Configuration
REQ-031 SHALL, with ROCC_TIMEOUT_EN defined, implement a TMO_W-bit watchdog counter with the following behaviour:
- cleared on entry to WAIT, incremented each cycle in WAIT;
- on reaching all-ones without engine_done: set err[2], pulse cmd_done next cycle, return to IDLE;
- a subsequent stray engine_done is ignored.
REQ-032 SHALL, without ROCC_TIMEOUT_EN, omit the counter, keep err[2] constant 0, and wait in WAIT indefinitely.

Verification
REQ-033 SHALL cover SETAB: opcode 0x0B, funct7 0x00, rs1=0x1000, rs2=0x2000 -> cfg_a_addr=0x1000, cfg_b_addr=0x2000, cmd_done high exactly in cycle N+1.
REQ-034 SHALL cover COMPUTE after SETCD with rs2=(4<<20)|(4<<10)|4:
- engine_start pulses in cycle N+1;
- engine_done applied 20 cycles later -> cmd_done one cycle after it;
- busy drops to 0 the cycle after cmd_done.
REQ-035 SHALL cover illegal command funct7 0x7F -> err=3'b001, cfg unchanged, cmd_done at N+1; CLRERR -> err=0.
REQ-036 SHALL cover cmd_valid pulsed during WAIT -> err[1]=1, command ignored, no extra cmd_done.
REQ-037 SHALL cover rst asserted in WAIT -> immediately IDLE with all outputs 0; a later engine_done produces no cmd_done.
REQ-038 SHALL cover, with ROCC_TIMEOUT_EN and TMO_W=4, COMPUTE with no engine_done -> err[2]=1 and cmd_done 16 cycles after WAIT entry.

Source files
------------

// File: rtl/rocc_cmd_responder.sv
// RoCC command front-end: decodes custom-0 instructions into matrix-engine configuration,
// launches the systolic engine and returns completion. Optional watchdog via ROCC_TIMEOUT_EN.
module rocc_cmd_responder #(
    parameter int DIM_W = 10,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_instr,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             cmd_done,
    output logic [31:0]      cfg_a_addr,
    output logic [31:0]      cfg_b_addr,
    output logic [31:0]      cfg_c_addr,
    output logic [DIM_W-1:0] cfg_m,
    output logic [DIM_W-1:0] cfg_n,
    output logic [DIM_W-1:0] cfg_k,
    output logic             engine_start,
    input  logic             engine_done,
    output logic             busy,
    output logic [2:0]       err
);

    typedef enum logic [2:0] {IDLE, RESP, START, WAIT, DONE} state_t;

    state_t     state, state_nx;
    logic [6:0] funct7;
    logic       is_custom, accept, dims_ok, legal, timeout;
    logic       op_setab, op_setcd, op_compute, op_clrerr;
    logic       unused_bits;

    assign funct7     = cmd_instr[31:25];
    assign is_custom  = (cmd_instr[6:0] == 7'b0001011);
    assign accept     = (state == IDLE) && cmd_valid;
    assign op_setab   = is_custom && (funct7 == 7'h00);
    assign op_setcd   = is_custom && (funct7 == 7'h01);
    assign op_compute = is_custom && (funct7 == 7'h02);
    assign op_clrerr  = is_custom && (funct7 == 7'h03);
    assign dims_ok    = (cfg_m != '0) && (cfg_n != '0) && (cfg_k != '0);
    assign legal      = op_setab || op_setcd || op_clrerr || (op_compute && dims_ok);
    assign busy       = (state != IDLE);

`ifdef ROCC_TIMEOUT_EN
    logic [TMO_W-1:0] wdog_cnt;

    // Watchdog restarts while the engine is being launched and runs only in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == START) begin
            wdog_cnt <= '0;
        end else if (state == WAIT) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign timeout     = (state == WAIT) && !engine_done && (wdog_cnt == '1);
    assign unused_bits = ^{cmd_instr[24:7], cmd_rs2};
`else
    assign timeout     = 1'b0;
    assign unused_bits = ^{cmd_instr[24:7], cmd_rs2, TMO_W[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cmd_done     = 1'b0;
        engine_start = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = (op_compute && dims_ok) ? START : RESP;
                end
            end
            RESP: begin
                cmd_done = 1'b1;
                state_nx = IDLE;
            end
            START: begin
                engine_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (engine_done || timeout) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                cmd_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Configuration only changes on an accepted command, so it is frozen while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_a_addr <= '0;
            cfg_b_addr <= '0;
            cfg_c_addr <= '0;
            cfg_m      <= '0;
            cfg_n      <= '0;
            cfg_k      <= '0;
        end else if (accept) begin
            if (op_setab) begin
                cfg_a_addr <= cmd_rs1;
                cfg_b_addr <= cmd_rs2;
            end
            if (op_setcd) begin
                cfg_c_addr <= cmd_rs1;
                cfg_m      <= cmd_rs2[DIM_W-1:0];
                cfg_n      <= cmd_rs2[2*DIM_W-1:DIM_W];
                cfg_k      <= cmd_rs2[3*DIM_W-1:2*DIM_W];
            end
        end
    end

    // Sticky error flags; an accepted CLRERR wins over anything raised in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
        end else if (accept && op_clrerr) begin
            err <= '0;
        end else begin
            err <= err | {timeout, cmd_valid && (state != IDLE), accept && !legal};
        end
    end

endmodule

// File: tb/tb_rocc_cmd_responder.sv
// Self-checking bench for rocc_cmd_responder: table-driven command vectors plus
// hand-written compute, overrun, reset-in-WAIT and (with ROCC_TIMEOUT_EN) watchdog sequences.
module tb_rocc_cmd_responder;

    localparam int DIM_W = 10;
    localparam int TMO_W = 4;

    typedef struct {
        logic [31:0] err;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] m;
        logic [31:0] n;
        logic [31:0] k;
    } exp_t;

    typedef struct {
        logic [6:0]  f7;
        logic [6:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        want;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [31:0]      cmd_instr = '0;
    logic [31:0]      cmd_rs1 = '0;
    logic [31:0]      cmd_rs2 = '0;
    logic             engine_done = 1'b0;
    logic             cmd_done, engine_start, busy;
    logic [31:0]      cfg_a_addr, cfg_b_addr, cfg_c_addr;
    logic [DIM_W-1:0] cfg_m, cfg_n, cfg_k;
    logic [2:0]       err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[9];

    rocc_cmd_responder #(.DIM_W(DIM_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_instr(cmd_instr),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_done(cmd_done),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr), .cfg_c_addr(cfg_c_addr),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .engine_start(engine_start),
        .engine_done(engine_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [31:0] e, a, b, c, m, n, k);
        exp_t r;
        r.err = e; r.a = a; r.b = b; r.c = c; r.m = m; r.n = n; r.k = k;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [6:0] f7, op, input logic [31:0] rs1, rs2, input exp_t w);
        vec_t v;
        v.f7 = f7; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.want = w;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Called just after a falling edge: command is accepted on the next rising edge,
    // and the task returns at the falling edge inside cycle N+1.
    task automatic apply_stimulus(input logic [6:0] f7, op, input logic [31:0] rs1, rs2);
        cmd_valid = 1'b1;
        cmd_instr = {f7, 18'h0, op};
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Scoreboard consumer: every cmd_done must match a queued expectation
    always @(negedge clk) begin
        if (!rst && cmd_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                exp_t w;
                w = sb_q.pop_front();
                check_output("sb_err", {29'h0, err}, w.err);
                check_output("sb_a", cfg_a_addr, w.a);
                check_output("sb_b", cfg_b_addr, w.b);
                check_output("sb_c", cfg_c_addr, w.c);
                check_output("sb_m", {22'h0, cfg_m}, w.m);
                check_output("sb_n", {22'h0, cfg_n}, w.n);
                check_output("sb_k", {22'h0, cfg_k}, w.k);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int stray;

        vecs[0] = mk_vec(7'h00, 7'h0B, 32'h1000, 32'h2000, mk_exp(0, 32'h1000, 32'h2000, 0, 0, 0, 0));
        vecs[1] = mk_vec(7'h7F, 7'h0B, 32'hDEAD, 32'hBEEF, mk_exp(1, 32'h1000, 32'h2000, 0, 0, 0, 0));
        vecs[2] = mk_vec(7'h03, 7'h0B, 32'h0, 32'h0, mk_exp(0, 32'h1000, 32'h2000, 0, 0, 0, 0));
        vecs[3] = mk_vec(7'h02, 7'h0B, 32'h0, 32'h0, mk_exp(1, 32'h1000, 32'h2000, 0, 0, 0, 0));
        vecs[4] = mk_vec(7'h00, 7'h33, 32'hDEAD, 32'hBEEF, mk_exp(1, 32'h1000, 32'h2000, 0, 0, 0, 0));
        vecs[5] = mk_vec(7'h01, 7'h0B, 32'h3000, 32'h0040_1004, mk_exp(1, 32'h1000, 32'h2000, 32'h3000, 4, 4, 4));
        vecs[6] = mk_vec(7'h03, 7'h0B, 32'h0, 32'h0, mk_exp(0, 32'h1000, 32'h2000, 32'h3000, 4, 4, 4));
        vecs[7] = mk_vec(7'h01, 7'h0B, 32'h4000, 32'hC030_0801, mk_exp(0, 32'h1000, 32'h2000, 32'h4000, 1, 2, 3));
        vecs[8] = mk_vec(7'h01, 7'h0B, 32'h3000, 32'h0040_1004, mk_exp(0, 32'h1000, 32'h2000, 32'h3000, 4, 4, 4));

        @(negedge clk);
        check_output("rst_outputs", {cmd_done, engine_start, busy, err}, 0);
        check_output("rst_cfg", cfg_a_addr | cfg_b_addr | cfg_c_addr | {22'h0, cfg_m | cfg_n | cfg_k}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(vecs[i].want);
            apply_stimulus(vecs[i].f7, vecs[i].op, vecs[i].rs1, vecs[i].rs2);
            check_output($sformatf("done_n1_v%0d", i), {31'h0, cmd_done}, 1);
            check_output($sformatf("no_start_v%0d", i), {31'h0, engine_start}, 0);
            @(negedge clk);
            check_output($sformatf("idle_after_v%0d", i), {30'h0, cmd_done, busy}, 0);
        end

        // COMPUTE with stray engine_done in START and an overrun command in WAIT
        sb_q.push_back(mk_exp(2, 32'h1000, 32'h2000, 32'h3000, 4, 4, 4));
        apply_stimulus(7'h02, 7'h0B, 32'h0, 32'h0);
        check_output("start_n1", {29'h0, engine_start, cmd_done, busy}, 3'b101);
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
        check_output("wait_entered", {30'h0, engine_start, busy}, 2'b01);
        apply_stimulus(7'h01, 7'h0B, 32'h0BAD, 32'h0);
        check_output("overrun_err", {29'h0, err}, 3'b010);
        check_output("overrun_cfg_c", cfg_c_addr, 32'h3000);
        stray = 0;
        for (int i = 0; i < 18; i++) begin
            stray += int'(cmd_done) + int'(engine_start);
            @(negedge clk);
        end
        check_output("wait_quiet", stray, 0);
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
        check_output("done_w1", {30'h0, cmd_done, busy}, 2'b11);
        @(negedge clk);
        check_output("busy_drop", {30'h0, cmd_done, busy}, 0);

        // Reset while in WAIT, then a late engine_done must be ignored
        apply_stimulus(7'h02, 7'h0B, 32'h0, 32'h0);
        check_output("start_pre_rst", {31'h0, engine_start}, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("rst_wait_outputs", {cmd_done, engine_start, busy, err}, 0);
        check_output("rst_wait_cfg", cfg_a_addr | cfg_b_addr | cfg_c_addr | {22'h0, cfg_m | cfg_n | cfg_k}, 0);
        @(negedge clk);
        rst = 1'b0;
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            stray += int'(cmd_done) + int'(busy);
            @(negedge clk);
        end
        check_output("late_done_ignored", stray, 0);

`ifdef ROCC_TIMEOUT_EN
        sb_q.push_back(mk_exp(0, 0, 0, 32'h3000, 4, 4, 4));
        apply_stimulus(7'h01, 7'h0B, 32'h3000, 32'h0040_1004);
        check_output("tmo_setcd_done", {31'h0, cmd_done}, 1);
        @(negedge clk);
        sb_q.push_back(mk_exp(4, 0, 0, 32'h3000, 4, 4, 4));
        apply_stimulus(7'h02, 7'h0B, 32'h0, 32'h0);
        check_output("tmo_start", {31'h0, engine_start}, 1);
        stray = 0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) stray += int'(cmd_done);
        end
        check_output("tmo_quiet", stray, 0);
        check_output("tmo_done", {28'h0, cmd_done, err}, 4'b1100);
        @(negedge clk);
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            stray += int'(cmd_done) + int'(busy);
            @(negedge clk);
        end
        check_output("tmo_stray_ignored", stray, 0);
`endif

        check_output("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
